// File: rtl/msp_rx.sv
// MSP v1 request receiver: hunts "$M<", captures len/cmd/payload,
// checks the XOR checksum and holds the request until the responder takes it.
module msp_rx #(
  parameter int MAX_PAYLOAD    = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               req_cmd,
  output logic [7:0]               req_len,
  output logic [MAX_PAYLOAD*8-1:0] req_payload,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     crc_err,
  output logic                     len_err,
  output logic                     timeout_err,
  output logic                     rx_dropped,
  output logic                     busy
);

  localparam int          PW       = MAX_PAYLOAD * 8;
  localparam logic [7:0]  MAXP     = 8'(MAX_PAYLOAD);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  CH_DLR   = 8'h24;
  localparam logic [7:0]  CH_M     = 8'h4D;
  localparam logic [7:0]  CH_LT    = 8'h3C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_M,
    S_HDR_DIR,
    S_LEN,
    S_CMD,
    S_DATA,
    S_CRC,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [7:0]      req_cmd_q, req_cmd_d;
  logic [7:0]      req_len_q, req_len_d;
  logic [PW-1:0]   req_pay_q, req_pay_d;
  logic            req_valid_q, req_valid_d;
  logic            crc_err_q, crc_err_d;
  logic            len_err_q, len_err_d;
  logic            tmo_err_q, tmo_err_d;
  logic            drop_q, drop_d;
  logic            tmo_act;
  logic            tmo_hit;

  assign tmo_act = (state_q != S_IDLE) && (state_q != S_HOLD);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && tmo_act && !rx_valid
                   && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    pay_d       = pay_q;
    req_cmd_d   = req_cmd_q;
    req_len_d   = req_len_q;
    req_pay_d   = req_pay_q;
    req_valid_d = req_valid_q;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    tmo_err_d   = 1'b0;
    drop_d      = 1'b0;
    tmo_d       = (!tmo_act || rx_valid) ? 32'd0 : tmo_q + 32'd1;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == CH_DLR) state_d = S_HDR_M;
      end
      S_HDR_M: begin
        if (rx_valid) begin
          if (rx_data == CH_M)        state_d = S_HDR_DIR;
          else if (rx_data != CH_DLR) state_d = S_IDLE;
        end
      end
      S_HDR_DIR: begin
        if (rx_valid) begin
          if (rx_data == CH_LT)       state_d = S_LEN;
          else if (rx_data == CH_DLR) state_d = S_HDR_M;
          else                        state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data > MAXP) begin
            len_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_data;
            csum_d  = rx_data;
            pay_d   = '0;
            idx_d   = 8'd0;
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = (len_q == 8'd0) ? S_CRC : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          pay_d[int'(idx_q)*8 +: 8] = rx_data;
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_q) state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            req_cmd_d   = cmd_q;
            req_len_d   = len_q;
            req_pay_d   = pay_q;
            req_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            crc_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // a '$' on the handshake cycle starts the next frame
        if (req_valid_q && req_ready) begin
          req_valid_d = 1'b0;
          state_d     = (rx_valid && rx_data == CH_DLR) ? S_HDR_M : S_IDLE;
        end else if (rx_valid) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      tmo_err_d = 1'b1;
      tmo_d     = 32'd0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      cmd_q       <= 8'd0;
      idx_q       <= 8'd0;
      csum_q      <= 8'd0;
      pay_q       <= '0;
      tmo_q       <= 32'd0;
      req_cmd_q   <= 8'd0;
      req_len_q   <= 8'd0;
      req_pay_q   <= '0;
      req_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      pay_q       <= pay_d;
      tmo_q       <= tmo_d;
      req_cmd_q   <= req_cmd_d;
      req_len_q   <= req_len_d;
      req_pay_q   <= req_pay_d;
      req_valid_q <= req_valid_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      tmo_err_q   <= tmo_err_d;
      drop_q      <= drop_d;
    end
  end

  assign req_cmd     = req_cmd_q;
  assign req_len     = req_len_q;
  assign req_payload = req_pay_q;
  assign req_valid   = req_valid_q;
  assign crc_err     = crc_err_q;
  assign len_err     = len_err_q;
  assign timeout_err = tmo_err_q;
  assign rx_dropped  = drop_q;
  assign busy        = (state_q != S_IDLE);

endmodule
